macc_divider: RTL and testbench

//  Iterative restoring divider: inverse of the MACC path (P = A*B + CARRYIN).

---
 rtl/macc_div_pkg.sv | 12 +
 rtl/macc_divider_div_step.sv | 26 ++
 rtl/macc_divider.sv | 107 ++++++++++
 tb/tb_macc_divider.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/macc_div_pkg.sv
// Shared types and default widths for the MACC-path restoring divider.
package macc_div_pkg;
  localparam int DEF_DW = 48;
  localparam int DEF_VW = 18;
  localparam int CW     = $clog2(DEF_DW);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

// File: rtl/macc_divider_div_step.sv
// One radix-2 restoring step: shift in a dividend bit, trial-subtract the divisor.
module div_step #(
  parameter int VW = 18
) (
  input  logic [VW:0]   r_i,
  input  logic          bit_i,
  input  logic [VW-1:0] divisor_i,
  output logic [VW:0]   r_o,
  output logic          q_o
);
  logic [VW:0] shifted;
  logic [VW:0] dvs_ext;

  // The partial remainder is always below the divisor, so its top bit is dropped on the shift.
  assign shifted = {r_i[VW-1:0], bit_i};
  assign dvs_ext = {1'b0, divisor_i};

  always_comb begin
    r_o = shifted;
    q_o = 1'b0;
    if (shifted >= dvs_ext) begin
      r_o = shifted - dvs_ext;
      q_o = 1'b1;
    end
  end
endmodule

// File: rtl/macc_divider.sv
// Iterative restoring divider, one quotient bit per clock, valid/ready on both sides.
// Handshake: a transfer happens on a rising edge where valid and ready are both high;
// the producer holds data stable while valid is high, and ready never depends on valid.
module macc_divider
  import macc_div_pkg::*;
#(
  parameter int DW = DEF_DW,
  parameter int VW = DEF_VW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] quotient,
  output logic [VW-1:0] remainder,
  output logic          div_zero,
  output state_t        dbg_state
);
  localparam int CNT_W = $clog2(DW);

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [DW-1:0]    sr_q;
  logic [VW-1:0]    dvs_q;
  logic [VW:0]      rem_q;
  logic             dz_q;
  logic             in_ready_q;
  logic             out_valid_q;

  logic [VW:0]      rem_d;
  logic             q_bit;

  div_step #(.VW(VW)) u_step (
    .r_i       (rem_q),
    .bit_i     (sr_q[DW-1]),
    .divisor_i (dvs_q),
    .r_o       (rem_d),
    .q_o       (q_bit)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      sr_q        <= '0;
      dvs_q       <= '0;
      rem_q       <= '0;
      dz_q        <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          // in_ready rises one edge after reset release; acceptance needs it already high.
          in_ready_q <= 1'b1;
          if (in_valid && in_ready_q) begin
            in_ready_q <= 1'b0;
            dvs_q      <= divisor;
            if (divisor == '0) begin
              sr_q        <= '1;
              rem_q       <= {1'b0, dividend[VW-1:0]};
              dz_q        <= 1'b1;
              out_valid_q <= 1'b1;
              state_q     <= DONE;
            end else begin
              sr_q    <= dividend;
              rem_q   <= '0;
              dz_q    <= 1'b0;
              cnt_q   <= CNT_W'(DW - 1);
              state_q <= CALC;
            end
          end
        end
        CALC: begin
          // Dividend bits leave at the top while quotient bits enter at the bottom.
          sr_q  <= {sr_q[DW-2:0], q_bit};
          rem_q <= rem_d;
          if (cnt_q == '0) begin
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign quotient  = sr_q;
  assign remainder = rem_q[VW-1:0];
  assign div_zero  = dz_q;
  assign dbg_state = state_q;
endmodule

// File: tb/tb_macc_divider.sv
// Self-checking bench for macc_divider: directed corner cases plus a MACC-style random sweep.
module tb_macc_divider;
  import macc_div_pkg::*;

  localparam int DW = 48;
  localparam int VW = 18;
  localparam int W  = DW + VW + 1;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] dividend;
  logic [VW-1:0] divisor;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] quotient;
  logic [VW-1:0] remainder;
  logic          div_zero;
  state_t        dbg_state;

  logic [W-1:0]  exp_q[$];
  int            n_total;
  int            n_pass;

  macc_divider #(.DW(DW), .VW(VW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dividend  (dividend),
    .divisor   (divisor),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quotient  (quotient),
    .remainder (remainder),
    .div_zero  (div_zero),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  // driver: wait for in_ready, transfer one operand pair, push the model result
  task automatic send(input logic [DW-1:0] a, input logic [VW-1:0] b);
    int waited;
    logic [63:0] a64, b64;
    logic [DW-1:0] eq;
    logic [VW-1:0] er;
    waited = 0;
    while (!in_ready && waited < 200) begin
      @(posedge clk); #1;
      waited++;
    end
    check_eq("in_ready_wait", {63'd0, in_ready}, 64'd1);
    in_valid = 1'b1;
    dividend = a;
    divisor  = b;
    if (b == '0) begin
      eq = '1;
      er = a[VW-1:0];
    end else begin
      a64 = {16'd0, a};
      b64 = {46'd0, b};
      eq  = DW'(a64 / b64);
      er  = VW'(a64 % b64);
    end
    exp_q.push_back({(b == '0), er, eq});
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // monitor/scoreboard: wait for out_valid, compare, hold for `hold` cycles, then handshake
  task automatic collect(input int hold);
    int lat;
    logic [W-1:0] e;
    logic [DW-1:0] eq;
    logic [VW-1:0] er;
    logic ez;
    lat = 0;
    while (!out_valid && lat < DW + 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check_eq("out_valid_seen", {63'd0, out_valid}, 64'd1);
    if (exp_q.size() == 0) begin
      check_eq("exp_q_empty", 64'(exp_q.size()), 64'd1);
      return;
    end
    e  = exp_q.pop_front();
    eq = e[DW-1:0];
    er = e[DW+VW-1:DW];
    ez = e[W-1];
    check_eq("latency", 64'(lat), ez ? 64'd0 : 64'(DW));
    check_eq("quotient", {16'd0, quotient}, {16'd0, eq});
    check_eq("remainder", {46'd0, remainder}, {46'd0, er});
    check_eq("div_zero", {63'd0, div_zero}, {63'd0, ez});
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      dividend = DW'({$urandom, $urandom});
      divisor  = VW'($urandom);
      @(posedge clk); #1;
      check_eq("bp_in_ready", {63'd0, in_ready}, 64'd0);
      check_eq("bp_out_valid", {63'd0, out_valid}, 64'd1);
      check_eq("bp_quotient", {16'd0, quotient}, {16'd0, eq});
      check_eq("bp_remainder", {46'd0, remainder}, {46'd0, er});
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check_eq("post_hs_out_valid", {63'd0, out_valid}, 64'd0);
    check_eq("post_hs_in_ready", {63'd0, in_ready}, 64'd1);
  endtask

  initial begin
    logic [63:0] a_m, b_m, c_m, p_m;
    n_total   = 0;
    n_pass    = 0;
    rst       = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    dividend  = '0;
    divisor   = '0;

    #12;
    check_eq("rst_in_ready", {63'd0, in_ready}, 64'd0);
    check_eq("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check_eq("rst_quotient", {16'd0, quotient}, 64'd0);
    check_eq("rst_remainder", {46'd0, remainder}, 64'd0);
    check_eq("rst_div_zero", {63'd0, div_zero}, 64'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check_eq("first_in_ready", {63'd0, in_ready}, 64'd1);

    // directed cases
    send(48'd100, 18'd7);                 collect(0);
    send('1, 18'd1);                      collect(0);
    send('1, '1);                         collect(0);
    send(48'h12345, 18'd0);               collect(0);
    send(48'd0, 18'd5);                   collect(0);
    send(48'd3, 18'h3FFFF);               collect(0);
    send(48'h8000_0000_0000, 18'd3);      collect(10);

    // asynchronous reset in the middle of an iteration
    send('1, 18'd3);
    repeat (19) @(posedge clk);
    #2;
    check_eq("mid_state_calc", {62'd0, dbg_state}, {62'd0, CALC});
    rst = 1'b0;
    #1;
    check_eq("arst_quotient", {16'd0, quotient}, 64'd0);
    check_eq("arst_remainder", {46'd0, remainder}, 64'd0);
    check_eq("arst_out_valid", {63'd0, out_valid}, 64'd0);
    check_eq("arst_in_ready", {63'd0, in_ready}, 64'd0);
    check_eq("arst_div_zero", {63'd0, div_zero}, 64'd0);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b1;
    send(48'd48, 18'd6);                  collect(0);

    // MACC-style sweep: P = A*B + cin with cin < B must give back A and cin
    for (int n = 0; n < 1000; n++) begin
      a_m = 64'($urandom & 32'h3FFF_FFFF);
      b_m = 64'($urandom_range(1, 18'h3FFFF));
      c_m = 64'($urandom_range(0, 32'(b_m - 1)));
      p_m = a_m * b_m + c_m;
      send(p_m[DW-1:0], b_m[VW-1:0]);
      check_eq("macc_model_q", {16'd0, exp_q[0][DW-1:0]}, a_m);
      check_eq("macc_model_r", {46'd0, exp_q[0][DW+VW-1:DW]}, c_m);
      collect($urandom_range(0, 2));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
